fetch_stall_ctrl: RTL and testbench

Fetch-side responder for the pipeline interlock. It owns the PC register and the IF/ID pipeline register, and acts on the stall, flush and redirect controls raised by the hazard detector and the EX/MEM branch logic. It sits between instruction memory and decode. Each cycle it decides whether to advance, hold, bubble or redirect. It also keeps saturating counters of stall and bubble cycles for performance bring-up.

---
 rtl/fetch_stall_ctrl_if.sv | 35 +++
 rtl/fetch_stall_ctrl.sv | 136 +++++++++++++
 tb/tb_fetch_stall_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/fetch_stall_ctrl_if.sv
// Fetch/interlock bundle between the hazard logic, instruction memory and decode.
// The master drives the control inputs; the slave is fetch_stall_ctrl itself.
interface fetch_stall_ctrl_if #(
  parameter int CNT_W = 16
) ();
  logic             stallCtrl;
  logic             jumpFlush;
  logic             Jump_IDEX;
  logic [15:0]      jumpTarget;
  logic             takeBranch_EXMEM;
  logic [15:0]      branchTarget;
  logic             halt_IFID;
  logic [15:0]      instr_in;
  logic [15:0]      pc;
  logic [15:0]      instr_IFID;
  logic [15:0]      pcPlus2_IFID;
  logic             valid_IFID;
  logic             halted;
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] bubbleCnt;

  modport master (
    output stallCtrl, jumpFlush, Jump_IDEX, jumpTarget,
           takeBranch_EXMEM, branchTarget, halt_IFID, instr_in,
    input  pc, instr_IFID, pcPlus2_IFID, valid_IFID, halted,
           stallCnt, bubbleCnt
  );

  modport slave (
    input  stallCtrl, jumpFlush, Jump_IDEX, jumpTarget,
           takeBranch_EXMEM, branchTarget, halt_IFID, instr_in,
    output pc, instr_IFID, pcPlus2_IFID, valid_IFID, halted,
           stallCnt, bubbleCnt
  );
endinterface

// File: rtl/fetch_stall_ctrl.sv
// Fetch stage: owns PC and IF/ID, arbitrates branch > jump > flush > hold > advance
// each cycle, and keeps saturating stall/bubble counters.
module fetch_stall_ctrl #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter int          CNT_W     = 16
) (
  input logic               clk,
  input logic               rst,
  fetch_stall_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ACT_ADVANCE,
    ACT_HOLD,
    ACT_FLUSH,
    ACT_JUMP,
    ACT_BRANCH
  } action_e;

  localparam int CNT_STALL  = 0;
  localparam int CNT_BUBBLE = 1;

  action_e     w_action;
  logic [15:0] r_pc;
  logic [15:0] r_instr;
  logic [15:0] r_pc_plus2;
  logic        r_valid;
  logic        r_halted;

  logic [15:0] w_fetch_plus2;
  logic [15:0] w_pc_next;
  logic [15:0] w_instr_next;
  logic [15:0] w_pc_plus2_next;
  logic        w_valid_next;
  logic        w_halt_set;
  logic [1:0]  w_cnt_inc;

  assign w_fetch_plus2 = r_pc + 16'd2;

  always_comb begin
    w_action = ACT_ADVANCE;
    if (bus.takeBranch_EXMEM) begin
      w_action = ACT_BRANCH;
    end else if (bus.Jump_IDEX) begin
      w_action = ACT_JUMP;
    end else if (bus.jumpFlush) begin
      w_action = ACT_FLUSH;
    end else if (bus.stallCtrl || r_halted) begin
      w_action = ACT_HOLD;
    end
  end

  // A bubble keeps pcPlus2_IFID so the stale link value never changes under a NOP.
  always_comb begin
    w_pc_next       = r_pc;
    w_instr_next    = r_instr;
    w_pc_plus2_next = r_pc_plus2;
    w_valid_next    = r_valid;
    w_cnt_inc       = 2'b00;
    unique case (w_action)
      ACT_BRANCH: begin
        w_pc_next              = bus.branchTarget;
        w_instr_next           = NOP_INSTR;
        w_valid_next           = 1'b0;
        w_cnt_inc[CNT_BUBBLE]  = 1'b1;
      end
      ACT_JUMP: begin
        w_pc_next              = bus.jumpTarget;
        w_instr_next           = NOP_INSTR;
        w_valid_next           = 1'b0;
        w_cnt_inc[CNT_BUBBLE]  = 1'b1;
      end
      ACT_FLUSH: begin
        w_instr_next           = NOP_INSTR;
        w_valid_next           = 1'b0;
        w_cnt_inc[CNT_BUBBLE]  = 1'b1;
      end
      ACT_HOLD: begin
        w_cnt_inc[CNT_STALL]   = bus.stallCtrl && !r_halted;
      end
      ACT_ADVANCE: begin
        w_pc_next              = w_fetch_plus2;
        w_instr_next           = bus.instr_in;
        w_pc_plus2_next        = w_fetch_plus2;
        w_valid_next           = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // A redirect in the same cycle belongs to an older instruction, so it suppresses the halt.
  assign w_halt_set = bus.halt_IFID && r_valid && !bus.takeBranch_EXMEM && !bus.Jump_IDEX;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= RESET_PC;
      r_instr    <= NOP_INSTR;
      r_pc_plus2 <= 16'h0000;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_pc       <= w_pc_next;
      r_instr    <= w_instr_next;
      r_pc_plus2 <= w_pc_plus2_next;
      r_valid    <= w_valid_next;
      if (w_halt_set) begin
        r_halted <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] r_cnt;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_cnt <= '0;
        end else if (w_cnt_inc[gi] && !(&r_cnt)) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign bus.pc           = r_pc;
  assign bus.instr_IFID   = r_instr;
  assign bus.pcPlus2_IFID = r_pc_plus2;
  assign bus.valid_IFID   = r_valid;
  assign bus.halted       = r_halted;
  assign bus.stallCnt     = g_cnt[CNT_STALL].r_cnt;
  assign bus.bubbleCnt    = g_cnt[CNT_BUBBLE].r_cnt;

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Directed bench: stimulus pushes hand-computed post-edge state into a queue,
// a monitor pops one entry per clock and compares every output.
module tb_fetch_stall_ctrl;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_stall_ctrl_if #(.CNT_W(CW)) bus ();

  fetch_stall_ctrl #(
    .RESET_PC (16'h0000),
    .NOP_INSTR(16'h0800),
    .CNT_W    (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [15:0]   pc;
    logic [15:0]   instr;
    logic [15:0]   pcp2;
    logic          valid;
    logic          halted;
    logic [CW-1:0] sc;
    logic [CW-1:0] bc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_txn = 0;

  function automatic exp_t mk(input logic [15:0] p, input logic [15:0] i, input logic [15:0] p2,
                              input logic v, input logic h, input logic [CW-1:0] s,
                              input logic [CW-1:0] b);
    exp_t e;
    e.pc = p; e.instr = i; e.pcp2 = p2; e.valid = v; e.halted = h; e.sc = s; e.bc = b;
    return e;
  endfunction

  task automatic step(input logic r, input logic st, input logic fl, input logic jp,
                      input logic [15:0] jt, input logic br, input logic [15:0] bt,
                      input logic hl, input logic [15:0] ins, input exp_t e);
    @(negedge clk);
    rst                  = r;
    bus.stallCtrl        = st;
    bus.jumpFlush        = fl;
    bus.Jump_IDEX        = jp;
    bus.jumpTarget       = jt;
    bus.takeBranch_EXMEM = br;
    bus.branchTarget     = bt;
    bus.halt_IFID        = hl;
    bus.instr_in         = ins;
    exp_q.push_back(e);
  endtask

  task automatic adv(input logic [15:0] ins, input exp_t e);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, ins, e);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL txn %0d %s: got %h expected %h", n_txn, nm, act, req);
    end
  endtask

  // Monitor: outputs are registered, so every cycle is a transaction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_txn++;
        $display("txn %0d pc=%h instr=%h pc2=%h v=%b h=%b sc=%0d bc=%0d", n_txn, bus.pc,
                 bus.instr_IFID, bus.pcPlus2_IFID, bus.valid_IFID, bus.halted,
                 bus.stallCnt, bus.bubbleCnt);
        chk("pc", bus.pc, e.pc);
        chk("instr_IFID", bus.instr_IFID, e.instr);
        chk("pcPlus2_IFID", bus.pcPlus2_IFID, e.pcp2);
        chk("valid_IFID", 16'(bus.valid_IFID), 16'(e.valid));
        chk("halted", 16'(bus.halted), 16'(e.halted));
        chk("stallCnt", 16'(bus.stallCnt), 16'(e.sc));
        chk("bubbleCnt", 16'(bus.bubbleCnt), 16'(e.bc));
      end
    end
  end

  initial begin
    bus.stallCtrl = 1'b0; bus.jumpFlush = 1'b0; bus.Jump_IDEX = 1'b0; bus.jumpTarget = 16'h0;
    bus.takeBranch_EXMEM = 1'b0; bus.branchTarget = 16'h0; bus.halt_IFID = 1'b0;
    bus.instr_in = 16'h0;

    // Reset state held while rst is low
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'hAAAA,
                    mk(16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0, 4'd0, 4'd0));

    // Reset release and advance
    adv(16'h1111, mk(16'h0002, 16'h1111, 16'h0002, 1'b1, 1'b0, 4'd0, 4'd0));
    adv(16'h2222, mk(16'h0004, 16'h2222, 16'h0004, 1'b1, 1'b0, 4'd0, 4'd0));
    for (int p = 4; p <= 14; p += 2)
      adv(16'h3000 | 16'(p), mk(16'(p + 2), 16'h3000 | 16'(p), 16'(p + 2), 1'b1, 1'b0, 4'd0, 4'd0));

    // Three-cycle stall at 0x0010
    for (int k = 1; k <= 3; k++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h4010,
           mk(16'h0010, 16'h300E, 16'h0010, 1'b1, 1'b0, CW'(k), 4'd0));
    adv(16'h4010, mk(16'h0012, 16'h4010, 16'h0012, 1'b1, 1'b0, 4'd3, 4'd0));

    // Jump with two-cycle flush
    step(1'b1, 1'b0, 1'b1, 1'b1, 16'h0040, 1'b0, 16'h0, 1'b0, 16'h4012,
         mk(16'h0040, 16'h0800, 16'h0012, 1'b0, 1'b0, 4'd3, 4'd1));
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h5040,
         mk(16'h0040, 16'h0800, 16'h0012, 1'b0, 1'b0, 4'd3, 4'd2));
    adv(16'h5040, mk(16'h0042, 16'h5040, 16'h0042, 1'b1, 1'b0, 4'd3, 4'd2));

    // Branch beats jump and stall
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0200, 1'b1, 16'h0100, 1'b0, 16'h5042,
         mk(16'h0100, 16'h0800, 16'h0042, 1'b0, 1'b0, 4'd3, 4'd3));
    adv(16'h6100, mk(16'h0102, 16'h6100, 16'h0102, 1'b1, 1'b0, 4'd3, 4'd3));

    // Flush beats stall
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h6102,
         mk(16'h0102, 16'h0800, 16'h0102, 1'b0, 1'b0, 4'd3, 4'd4));
    adv(16'h6102, mk(16'h0104, 16'h6102, 16'h0104, 1'b1, 1'b0, 4'd3, 4'd4));

    // Halt: sets on the edge the valid HALT is seen, then freezes fetch
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h7104,
         mk(16'h0106, 16'h7104, 16'h0106, 1'b1, 1'b1, 4'd3, 4'd4));
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h7106,
         mk(16'h0106, 16'h7104, 16'h0106, 1'b1, 1'b1, 4'd3, 4'd4));
    adv(16'h7106, mk(16'h0106, 16'h7104, 16'h0106, 1'b1, 1'b1, 4'd3, 4'd4));
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0020, 1'b0, 16'h7106,
         mk(16'h0020, 16'h0800, 16'h0106, 1'b0, 1'b1, 4'd3, 4'd5));
    adv(16'h8020, mk(16'h0020, 16'h0800, 16'h0106, 1'b0, 1'b1, 4'd3, 4'd5));

    // Reset during a jump: halted clears, target forgotten
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0300, 1'b0, 16'h0, 1'b0, 16'h8000,
         mk(16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0, 4'd0, 4'd0));
    adv(16'h8000, mk(16'h0002, 16'h8000, 16'h0002, 1'b1, 1'b0, 4'd0, 4'd0));

    // PC wrap at 0xFFFE
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'hFFFE, 1'b0, 16'h8002,
         mk(16'hFFFE, 16'h0800, 16'h0002, 1'b0, 1'b0, 4'd0, 4'd1));
    adv(16'h9FFE, mk(16'h0000, 16'h9FFE, 16'h0000, 1'b1, 1'b0, 4'd0, 4'd1));

    // Counter saturation
    for (int k = 1; k <= 20; k++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'hA000,
           mk(16'h0000, 16'h9FFE, 16'h0000, 1'b1, 1'b0, CW'(k > 15 ? 15 : k), 4'd1));
    for (int k = 1; k <= 16; k++)
      step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'hA000,
           mk(16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0, 4'd15, CW'(k + 1 > 15 ? 15 : k + 1)));

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
